cfg_reg_ctrl: RTL and testbench
===============================

Name: cfg_reg_ctrl

Overview:
- Configuration initiator for an array of mode-configurable registers, each with a config_we/config_data port.
- Accepts write/read requests over a valid/ready request channel and decodes the address into a one-hot, one-cycle cfg_we pulse with cfg_data.
- Reads sample the addressed register's stored value and return it on a valid/ready response channel.
- Sits between the tile configuration bus and the register bank: the writer side of the registers' config interface.

Parameters:
- WIDTH, 4, data width of each configurable register.
- NUM_REGS, 4, number of registers driven (1..2^ADDR_W).
- ADDR_W, 2, request address width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESETN  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target register index.
- req_data  in  WIDTH  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  WIDTH  read data (0 for writes and errors).
- resp_err  out  1  address out of range (or verify mismatch, see Optional Feature).
- cfg_we  out  NUM_REGS  one-hot write strobe, register i at bit i.
- cfg_data  out  WIDTH  shared write data to all registers.
- cfg_rdata  in  NUM_REGS*WIDTH  stored value of each register, register i at bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset: the clock is CLK; reset is RESETN, synchronous and active-low.
  - While RESETN=0 at a rising edge: state=IDLE, req_ready=0 for that cycle, resp_valid=0, resp_data=0, resp_err=0, cfg_we=0, cfg_data=0.
  - Reset mid-transaction abandons it: no cfg_we pulse, no response.
- FSM states: IDLE, WRITE, READ, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/data.
    - addr >= NUM_REGS → RESP with resp_err=1, resp_data=0, and no cfg_we.
    - Write → WRITE. Read → READ.
  - WRITE (one cycle): cfg_we[addr]=1, cfg_data=latched data; all other cfg_we bits 0. Next state RESP with resp_err=0, resp_data=0.
  - READ (one cycle): capture cfg_rdata slice[addr] into resp_data. Next state RESP.
  - RESP: resp_valid=1. resp_data and resp_err stay stable until resp_valid&resp_ready, then → IDLE.
- req_ready=0 in every state except IDLE. One outstanding transaction; no pipelining.
- Latency, with acceptance at edge T:
  - Write strobe is high in cycle T+1; resp_valid rises in cycle T+2.
  - Read samples cfg_rdata in cycle T+1; resp_valid is high in cycle T+2.
  - A read immediately after a write to the same address returns the new value, because the register updates at the end of the WRITE cycle.
- cfg_we is registered and glitch-free. It is never asserted in IDLE, READ or RESP. cfg_data holds its last written value outside WRITE.
- A response stalled by resp_ready=0 holds indefinitely, and no new request is accepted.
- Back-to-back: a request may be accepted in the IDLE cycle immediately following the response handshake. Throughput is 1 transaction per 3 cycles.

Optional Feature:
- Macro: CFG_WRITE_VERIFY_EN.
- Defined:
  - After WRITE, the FSM enters an extra VERIFY state for one cycle.
  - VERIFY compares cfg_rdata[addr] with the latched data and goes to RESP with resp_err = mismatch and resp_data = the value read back.
  - Write latency to resp_valid becomes T+3. Reads are unchanged.
- Undefined:
  - The VERIFY state does not exist.
  - Write responses carry resp_err=0 (unless address out of range) and resp_data=0.

Decomposition:
- Shared package cfg_reg_pkg holds:
  - the FSM state enum (IDLE, WRITE, READ, RESP, VERIFY);
  - the default WIDTH/NUM_REGS/ADDR_W constants;
  - the response-status encoding shared with the bus-side master.
- One natural sub-module, cfg_addr_decode: combinational ADDR_W → NUM_REGS one-hot decode plus the out-of-range flag. It is reused by the readback mux select.
- Everything else lives in cfg_reg_ctrl.

Test Plan:
- Reset: hold RESETN=0 for 3 cycles with req_valid=1 → no handshake; resp_valid=0, cfg_we=0, cfg_data=0. After release, req_ready=1 in the next cycle.
- Write: addr=2, data=4'hA, resp_ready=1 → cfg_we=4'b0100 and cfg_data=4'hA for exactly one cycle at T+1; resp_valid at T+2 with resp_err=0.
- Readback: model registers capture the write → a read of addr=2 returns resp_data=4'hA at T+2. A read of addr=0 after reset returns 4'h0.
- Out-of-range: instantiate with NUM_REGS=3 and write addr=3 → no cfg_we bit ever set; resp_err=1 and resp_data=0 at T+1.
- Backpressure: hold resp_ready=0 for 5 cycles after read data 4'h5 → resp_valid, resp_data=4'h5 and resp_err stable; req_ready=0 throughout. The next request is accepted the cycle after the handshake.
- Verify (CFG_WRITE_VERIFY_EN): register model forces stored value 4'h3 on a write of 4'hC → resp_err=1 and resp_data=4'h3 at T+3. With a correct model, resp_err=0.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
// Shared types and default sizes for the configuration-register controller
// and the bus-side master that talks to it.
package cfg_reg_pkg;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_NUM_REGS = 4;
   localparam int DEF_ADDR_W   = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_READ   = 3'd2,
      ST_RESP   = 3'd3,
      ST_VERIFY = 3'd4
   } cfg_state_e;

   typedef enum logic {
      RESP_OK  = 1'b0,
      RESP_ERR = 1'b1
   } cfg_resp_e;

endpackage

// File: rtl/cfg_reg_ctrl_if.sv
// Request/response channel between the tile configuration bus master and
// the configuration-register controller.
interface cfg_reg_ctrl_if
   import cfg_reg_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [WIDTH-1:0]  req_data;
   logic              resp_valid;
   logic              resp_ready;
   logic [WIDTH-1:0]  resp_data;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_data, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );

endinterface

// File: rtl/cfg_addr_decode.sv
// Register index to one-hot select, plus a flag for indices past the last
// implemented register.
module cfg_addr_decode
   import cfg_reg_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [NUM_REGS-1:0] o_onehot,
   output logic                o_oor
);

   // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] LP_NUM = (ADDR_W+1)'(NUM_REGS);

   assign o_oor = ({1'b0, i_addr} >= LP_NUM);

   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         o_onehot[i] = (i_addr == ADDR_W'(i));
      end
   end

endmodule

// File: rtl/cfg_reg_ctrl.sv
// Configuration initiator: turns bus requests into one-cycle cfg_we strobes
// or register readbacks. Define CFG_WRITE_VERIFY_EN to read back every write.
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_WRITE  | cfg_we strobe for the latched register
// ST_READ   | capture the addressed register's stored value
// ST_VERIFY | compare written register against latched data
// ST_RESP   | hold response until resp_ready
module cfg_reg_ctrl
   import cfg_reg_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  logic                      CLK,
   input  logic                      RESETN,
   cfg_reg_ctrl_if.slave             bus,
   output logic [NUM_REGS-1:0]       cfg_we,
   output logic [WIDTH-1:0]          cfg_data,
   input  logic [NUM_REGS*WIDTH-1:0] cfg_rdata
);

   cfg_state_e          r_state;
   logic                r_req_ready;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_resp_valid;
   logic [WIDTH-1:0]    r_resp_data;
   cfg_resp_e           r_resp_err;
   logic [NUM_REGS-1:0] r_cfg_we;
   logic [WIDTH-1:0]    r_cfg_data;

   logic [ADDR_W-1:0]   w_dec_addr;
   logic [NUM_REGS-1:0] w_onehot;
   logic                w_oor;
   logic [WIDTH-1:0]    w_rsel;

   // The decoder serves the incoming address in IDLE and the latched one after.
   assign w_dec_addr = (r_state == ST_IDLE) ? bus.req_addr : r_addr;

   cfg_addr_decode #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_dec (
      .i_addr   (w_dec_addr),
      .o_onehot (w_onehot),
      .o_oor    (w_oor)
   );

   always_comb begin
      w_rsel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_onehot[i]) w_rsel = w_rsel | cfg_rdata[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b0;
         r_addr       <= '0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_err   <= RESP_OK;
         r_cfg_we     <= '0;
         r_cfg_data   <= '0;
      end else begin
         r_cfg_we <= '0;
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_addr      <= bus.req_addr;
                  if (w_oor) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_data  <= '0;
                     r_resp_err   <= RESP_ERR;
                  end else if (bus.req_write) begin
                     r_state    <= ST_WRITE;
                     r_cfg_we   <= w_onehot;
                     r_cfg_data <= bus.req_data;
                  end else begin
                     r_state <= ST_READ;
                  end
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            ST_WRITE: begin
`ifdef CFG_WRITE_VERIFY_EN
               r_state <= ST_VERIFY;
`else
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
               r_resp_data  <= '0;
               r_resp_err   <= RESP_OK;
`endif
            end
`ifdef CFG_WRITE_VERIFY_EN
            ST_VERIFY: begin
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
               r_resp_data  <= w_rsel;
               r_resp_err   <= (w_rsel != r_cfg_data) ? RESP_ERR : RESP_OK;
            end
`endif
            ST_READ: begin
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
               r_resp_data  <= w_rsel;
               r_resp_err   <= RESP_OK;
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  r_state      <= ST_IDLE;
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_data  = r_resp_data;
   assign bus.resp_err   = r_resp_err;
   assign cfg_we         = r_cfg_we;
   assign cfg_data       = r_cfg_data;

endmodule

// File: tb/tb_cfg_reg_ctrl.sv
// Bench for cfg_reg_ctrl (NUM_REGS=3 so index 3 is out of range): directed
// cases with literal expectations, then random traffic against a latency model.
module tb_cfg_reg_ctrl;

   localparam int W  = 4;
   localparam int N  = 3;
   localparam int AW = 2;
`ifdef CFG_WRITE_VERIFY_EN
   localparam int LAT_W = 3;
`else
   localparam int LAT_W = 2;
`endif

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   cfg_we;
   logic [W-1:0]   cfg_data;
   logic [N*W-1:0] cfg_rdata;
   logic [W-1:0]   bank [N] = '{default: '0};
   logic           fault = 1'b0;
   int             n_checks = 0;
   int             n_fail   = 0;

   cfg_reg_ctrl_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

   cfg_reg_ctrl #(.WIDTH(W), .NUM_REGS(N), .ADDR_W(AW)) u_dut (
      .CLK       (clk),
      .RESETN    (rst_n),
      .bus       (bus.slave),
      .cfg_we    (cfg_we),
      .cfg_data  (cfg_data),
      .cfg_rdata (cfg_rdata)
   );

   always #5 clk = ~clk;

   // Register bank; with fault set it stores 4'h3 regardless of the data.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (cfg_we[i]) bank[i] <= fault ? 4'h3 : cfg_data;
      end
   end
   assign cfg_rdata = {bank[2], bank[1], bank[0]};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: each accepted request fixes a strobe one cycle
   // later and a response after a fixed latency that holds until handshake.
   logic         mv = 1'b0, busy = 1'b0;
   logic         e_ready = 1'b0, e_rv = 1'b0, e_re = 1'b0, e_rchk = 1'b0;
   logic [N-1:0] e_we = '0;
   logic [W-1:0] e_cd = '0, e_rd = '0, stored;
   logic [W-1:0] mregs [N] = '{default: '0};
   int           k = 0, lat = 0;

   always @(negedge clk) begin
      if (mv) begin
         chk("cmp_req_ready", bus.req_ready, e_ready);
         chk("cmp_resp_valid", bus.resp_valid, e_rv);
         chk("cmp_cfg_we", cfg_we, e_we);
         chk("cmp_cfg_data", cfg_data, e_cd);
         if (e_rv || e_rchk) begin
            chk("cmp_resp_data", bus.resp_data, e_rd);
            chk("cmp_resp_err", bus.resp_err, e_re);
         end
      end
      if (!rst_n) begin
         mv = 1'b1; busy = 1'b0; e_ready = 1'b0; e_rv = 1'b0; e_rd = '0;
         e_re = 1'b0; e_we = '0; e_cd = '0; e_rchk = 1'b1;
      end else if (mv) begin
         e_rchk = 1'b0;
         if (busy) begin
            if (e_rv && bus.resp_ready) begin
               busy = 1'b0; e_rv = 1'b0; e_ready = 1'b1; e_we = '0;
            end else begin
               k++;
               e_we = '0;
               e_rv = (k >= lat);
            end
         end else if (e_ready && bus.req_valid) begin
            busy = 1'b1; k = 1; e_ready = 1'b0; e_we = '0;
            if (int'(bus.req_addr) >= N) begin
               lat = 1; e_rd = '0; e_re = 1'b1;
            end else if (bus.req_write) begin
               stored = fault ? 4'h3 : bus.req_data;
               mregs[bus.req_addr] = stored;
               e_we = N'(1 << bus.req_addr);
               e_cd = bus.req_data;
               lat  = LAT_W;
`ifdef CFG_WRITE_VERIFY_EN
               e_rd = stored; e_re = (stored != bus.req_data);
`else
               e_rd = '0; e_re = 1'b0;
`endif
            end else begin
               lat = 2; e_rd = mregs[bus.req_addr]; e_re = 1'b0;
            end
            e_rv = (lat == 1);
         end else begin
            e_ready = 1'b1; e_we = '0;
         end
      end
   end

   // Drives one request; reports wait-for-ready cycles, latency to resp_valid,
   // first response, and the strobe seen in the cycle after acceptance.
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input int stall, output int waits, output int rlat,
                       output logic [W-1:0] rd, output logic re,
                       output logic [N-1:0] we1, output logic [W-1:0] cd1);
      waits = 0; rlat = 0; rd = '0; re = 1'b0; we1 = '0; cd1 = '0;
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_data = d;
      bus.resp_ready = (stall == 0);
      @(negedge clk);
      while (!bus.req_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!bus.req_ready) begin
         chk("accept_timeout", bus.req_ready, 1);
         bus.req_valid = 1'b0;
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (j == 1) begin we1 = cfg_we; cd1 = cfg_data; end
         if (bus.resp_valid) begin
            rlat = j; rd = bus.resp_data; re = bus.resp_err;
            break;
         end
      end
      if (rlat == 0) begin
         chk("resp_timeout", bus.resp_valid, 1);
         return;
      end
      repeat (stall) begin @(posedge clk); #1; end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic reset_mid();
      int n = 0;
      bus.req_valid = 1'b1; bus.req_write = 1'($urandom);
      bus.req_addr = AW'($urandom_range(0, 3)); bus.req_data = W'($urandom);
      bus.resp_ready = 1'b0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      if (!bus.req_ready) chk("accept_timeout_rst", bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.resp_ready = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; bus.resp_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   int           waits, rlat;
   logic [W-1:0] rd, cd1;
   logic         re;
   logic [N-1:0] we1;

   initial begin
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_data = '0; bus.resp_ready = 1'b1;
      // Reset held 3 cycles with a request pending.
      bus.req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_resp_valid", bus.resp_valid, 0);
         chk("rst_cfg_we", cfg_we, 0);
         chk("rst_cfg_data", cfg_data, 0);
      end
      rst_n = 1'b1; bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rel_req_ready_lo", bus.req_ready, 0);
      @(negedge clk);
      chk("rel_req_ready_hi", bus.req_ready, 1);
      @(posedge clk); #1;

      send(1'b0, 2'd0, 4'h0, 0, waits, rlat, rd, re, we1, cd1);
      chk("rd0_lat", rlat, 2);
      chk("rd0_data", rd, 4'h0);
      chk("rd0_err", re, 0);

      send(1'b1, 2'd2, 4'hA, 0, waits, rlat, rd, re, we1, cd1);
      chk("wr2_we", we1, 3'b100);
      chk("wr2_data", cd1, 4'hA);
      chk("wr2_lat", rlat, LAT_W);
      chk("wr2_err", re, 0);

      send(1'b0, 2'd2, 4'h0, 0, waits, rlat, rd, re, we1, cd1);
      chk("rd2_data", rd, 4'hA);
      chk("rd2_waits", waits, 0);

      send(1'b1, 2'd3, 4'hF, 0, waits, rlat, rd, re, we1, cd1);
      chk("oor_lat", rlat, 1);
      chk("oor_err", re, 1);
      chk("oor_data", rd, 4'h0);
      chk("oor_we", we1, 0);

      send(1'b1, 2'd1, 4'h5, 0, waits, rlat, rd, re, we1, cd1);
      send(1'b0, 2'd1, 4'h0, 5, waits, rlat, rd, re, we1, cd1);
      chk("bp_data", rd, 4'h5);
      chk("bp_err", re, 0);
      send(1'b0, 2'd0, 4'h0, 0, waits, rlat, rd, re, we1, cd1);
      chk("b2b_waits", waits, 0);

`ifdef CFG_WRITE_VERIFY_EN
      fault = 1'b1;
      send(1'b1, 2'd0, 4'hC, 0, waits, rlat, rd, re, we1, cd1);
      fault = 1'b0;
      chk("vfy_bad_lat", rlat, 3);
      chk("vfy_bad_err", re, 1);
      chk("vfy_bad_data", rd, 4'h3);
      send(1'b1, 2'd0, 4'hC, 0, waits, rlat, rd, re, we1, cd1);
      chk("vfy_ok_err", re, 0);
      chk("vfy_ok_data", rd, 4'hC);
`endif

      for (int t = 0; t < 250; t++) begin
         if ($urandom_range(0, 14) == 0) begin
            reset_mid();
         end else begin
            send(1'($urandom), AW'($urandom_range(0, 3)), W'($urandom),
                 $urandom_range(0, 3), waits, rlat, rd, re, we1, cd1);
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
